// File: rtl/hms_alarm_clock.sv
// Hours/minutes/seconds clock with button-driven setup, alarm time entry and
// self-silencing alarm. All counting is enabled by a one-cycle tick from a prescaler.
module hms_alarm_clock #(
  parameter int unsigned CLK_HZ       = 50000000,
  parameter int unsigned DEBOUNCE_CYC = 500000,
  parameter int unsigned HOUR_MAX     = 23,
  parameter int unsigned ALARM_SEC    = 30
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       i_sw_mode,
  input  logic       i_sw_pos,
  input  logic       i_sw_inc,
  output logic [4:0] o_hour,
  output logic [5:0] o_min,
  output logic [5:0] o_sec,
  output logic [1:0] o_mode,
  output logic [1:0] o_position,
  output logic       o_alarm_en,
  output logic       o_alarm,
  output logic       o_blink
);

  localparam int unsigned PW = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
  localparam int unsigned DW = $clog2(DEBOUNCE_CYC + 1);
  localparam int unsigned RW = (ALARM_SEC > 1) ? $clog2(ALARM_SEC + 1) : 1;

  typedef enum logic [1:0] {ModeClock = 2'd0, ModeSetup = 2'd1, ModeAlarm = 2'd2} mode_e;
  typedef enum logic [1:0] {PosSec = 2'd0, PosMin = 2'd1, PosHour = 2'd2} pos_e;

  function automatic logic [5:0] wrap60(input logic [5:0] v);
    return (v == 6'd59) ? 6'd0 : v + 6'd1;
  endfunction

  function automatic logic [4:0] wrap_hr(input logic [4:0] v);
    return (v == 5'(HOUR_MAX)) ? 5'd0 : v + 5'd1;
  endfunction

  // Button conditioning; bit 0 = mode, 1 = pos, 2 = inc. Idle level is high.
  logic [2:0]    btn_raw;
  logic [2:0]    sync1_q, sync2_q, deb_q, deb_dly_q, press_q;
  logic [DW-1:0] dcnt_q [3];

  assign btn_raw = {i_sw_inc, i_sw_pos, i_sw_mode};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q   <= '1;
      sync2_q   <= '1;
      deb_q     <= '1;
      deb_dly_q <= '1;
      press_q   <= '0;
      for (int i = 0; i < 3; i++) dcnt_q[i] <= '0;
    end else begin
      sync1_q   <= btn_raw;
      sync2_q   <= sync1_q;
      deb_dly_q <= deb_q;
      press_q   <= deb_dly_q & ~deb_q;
      for (int i = 0; i < 3; i++) begin
        if (sync2_q[i] == deb_q[i]) begin
          dcnt_q[i] <= '0;
        end else if (dcnt_q[i] == DW'(DEBOUNCE_CYC - 1)) begin
          deb_q[i]  <= sync2_q[i];
          dcnt_q[i] <= '0;
        end else begin
          dcnt_q[i] <= dcnt_q[i] + 1'b1;
        end
      end
    end
  end

  logic          ev_mode, ev_pos, ev_inc, tick;
  logic [PW-1:0] presc_q, presc_d;
  mode_e         mode_q, mode_d;
  pos_e          pos_q, pos_d;
  logic [4:0]    hour_q, hour_d, al_hour_q, al_hour_d, disp_hour_q, disp_hour_d;
  logic [5:0]    min_q, min_d, sec_q, sec_d, al_min_q, al_min_d;
  logic [5:0]    disp_min_q, disp_min_d, disp_sec_q, disp_sec_d;
  logic          al_en_q, al_en_d, alarm_q, alarm_d, blink_q, blink_d;
  logic [RW-1:0] ring_q, ring_d;

  assign ev_mode = press_q[0];
  assign ev_pos  = press_q[1];
  assign ev_inc  = press_q[2];
  assign tick    = (presc_q == PW'(CLK_HZ - 1));

  always_comb begin
    presc_d   = tick ? '0 : presc_q + 1'b1;
    mode_d    = mode_q;
    pos_d     = pos_q;
    hour_d    = hour_q;
    min_d     = min_q;
    sec_d     = sec_q;
    al_hour_d = al_hour_q;
    al_min_d  = al_min_q;
    al_en_d   = al_en_q;
    alarm_d   = alarm_q;
    ring_d    = ring_q;

    // Timekeeping follows the mode held before any event in this cycle.
    if (tick && (mode_q != ModeSetup)) begin
      sec_d = wrap60(sec_q);
      if (sec_q == 6'd59) begin
        min_d = wrap60(min_q);
        if (min_q == 6'd59) hour_d = wrap_hr(hour_q);
      end
    end

    if (alarm_q && tick) begin
      if (ring_q == RW'(ALARM_SEC - 1)) begin
        alarm_d = 1'b0;
        ring_d  = '0;
      end else begin
        ring_d = ring_q + 1'b1;
      end
    end

    // A press while ringing only silences; it is not passed on.
    if (alarm_q && (|press_q)) begin
      alarm_d = 1'b0;
      ring_d  = '0;
    end else if (ev_mode) begin
      pos_d = PosSec;
      unique case (mode_q)
        ModeClock: mode_d = ModeSetup;
        ModeSetup: mode_d = ModeAlarm;
        default:   mode_d = ModeClock;
      endcase
    end else if (ev_pos) begin
      unique case (pos_q)
        PosSec:  pos_d = PosMin;
        PosMin:  pos_d = PosHour;
        default: pos_d = PosSec;
      endcase
    end else if (ev_inc) begin
      unique case (mode_q)
        ModeSetup: begin
          unique case (pos_q)
            PosSec:  sec_d  = wrap60(sec_q);
            PosMin:  min_d  = wrap60(min_q);
            default: hour_d = wrap_hr(hour_q);
          endcase
        end
        ModeAlarm: begin
          unique case (pos_q)
            PosSec:  al_en_d   = ~al_en_q;
            PosMin:  al_min_d  = wrap60(al_min_q);
            default: al_hour_d = wrap_hr(al_hour_q);
          endcase
        end
        default: ;
      endcase
    end

    if (tick && (mode_q != ModeSetup) && al_en_q && (hour_d == al_hour_q) &&
        (min_d == al_min_q) && (sec_d == 6'd0)) begin
      alarm_d = 1'b1;
      ring_d  = '0;
    end

    if (!al_en_d) begin
      alarm_d = 1'b0;
      ring_d  = '0;
    end

    if (mode_d == ModeAlarm) begin
      disp_hour_d = al_hour_d;
      disp_min_d  = al_min_d;
      disp_sec_d  = 6'd0;
    end else begin
      disp_hour_d = hour_d;
      disp_min_d  = min_d;
      disp_sec_d  = sec_d;
    end
    blink_d = (presc_d < PW'(CLK_HZ / 2));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc_q     <= '0;
      mode_q      <= ModeClock;
      pos_q       <= PosSec;
      hour_q      <= '0;
      min_q       <= '0;
      sec_q       <= '0;
      al_hour_q   <= '0;
      al_min_q    <= '0;
      al_en_q     <= 1'b0;
      alarm_q     <= 1'b0;
      ring_q      <= '0;
      disp_hour_q <= '0;
      disp_min_q  <= '0;
      disp_sec_q  <= '0;
      blink_q     <= 1'b1;
    end else begin
      presc_q     <= presc_d;
      mode_q      <= mode_d;
      pos_q       <= pos_d;
      hour_q      <= hour_d;
      min_q       <= min_d;
      sec_q       <= sec_d;
      al_hour_q   <= al_hour_d;
      al_min_q    <= al_min_d;
      al_en_q     <= al_en_d;
      alarm_q     <= alarm_d;
      ring_q      <= ring_d;
      disp_hour_q <= disp_hour_d;
      disp_min_q  <= disp_min_d;
      disp_sec_q  <= disp_sec_d;
      blink_q     <= blink_d;
    end
  end

  assign o_hour     = disp_hour_q;
  assign o_min      = disp_min_q;
  assign o_sec      = disp_sec_q;
  assign o_mode     = mode_q;
  assign o_position = pos_q;
  assign o_alarm_en = al_en_q;
  assign o_alarm    = alarm_q;
  assign o_blink    = blink_q;

endmodule

// File: tb/tb_hms_alarm_clock.sv
// Scoreboard bench for hms_alarm_clock: stimulus queues timed expectations,
// a negedge monitor compares them against the outputs when they fall due.
module tb_hms_alarm_clock;

  localparam logic [2:0]  BMode = 3'b001, BPos = 3'b010, BInc = 3'b100;
  localparam logic [23:0] MTime = 24'hFFFF80, MMode = 24'h000078, MEn = 24'h000004;
  localparam logic [23:0] MAl = 24'h000002, MBl = 24'h000001, MAll = 24'hFFFFFF;

  logic       clk = 1'b0, rst_n = 1'b0;
  logic       sw_mode = 1'b1, sw_pos = 1'b1, sw_inc = 1'b1;
  logic [4:0] o_hour;
  logic [5:0] o_min, o_sec;
  logic [1:0] o_mode, o_position;
  logic       o_alarm_en, o_alarm, o_blink;

  hms_alarm_clock #(
    .CLK_HZ      (10),
    .DEBOUNCE_CYC(4),
    .HOUR_MAX    (23),
    .ALARM_SEC   (3)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_sw_mode (sw_mode),
    .i_sw_pos  (sw_pos),
    .i_sw_inc  (sw_inc),
    .o_hour    (o_hour),
    .o_min     (o_min),
    .o_sec     (o_sec),
    .o_mode    (o_mode),
    .o_position(o_position),
    .o_alarm_en(o_alarm_en),
    .o_alarm   (o_alarm),
    .o_blink   (o_blink)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          due;
    string       name;
    logic [23:0] val;
    logic [23:0] mask;
  } exp_t;

  exp_t sb[$];
  int   n_vec = 0, n_fail = 0;
  int   r0 = 0;

  function automatic logic [23:0] pk(input int h, input int m, input int s, input int md,
                                     input int ps, input bit en, input bit al, input bit bl);
    return {5'(h), 6'(m), 6'(s), 2'(md), 2'(ps), en, al, bl};
  endfunction

  localparam logic [23:0] RstVal = {5'd0, 6'd0, 6'd0, 2'd0, 2'd0, 1'b0, 1'b0, 1'b1};

  task automatic expect_at(input int due, input string nm, input logic [23:0] v,
                           input logic [23:0] m);
    exp_t e;
    e.due  = due;
    e.name = nm;
    e.val  = v;
    e.mask = m;
    sb.push_back(e);
  endtask

  always @(negedge clk) begin : monitor
    logic [23:0] obs;
    obs = {o_hour, o_min, o_sec, o_mode, o_position, o_alarm_en, o_alarm, o_blink};
    for (int i = sb.size() - 1; i >= 0; i--) begin
      if (sb[i].due <= cyc) begin
        n_vec++;
        if ((sb[i].due != cyc) || (((obs ^ sb[i].val) & sb[i].mask) !== 24'h0)) begin
          n_fail++;
          $display("FAIL %s @cyc %0d (due %0d): got %h, want %h (mask %h)", sb[i].name, cyc,
                   sb[i].due, obs & sb[i].mask, sb[i].val & sb[i].mask, sb[i].mask);
        end
        sb.delete(i);
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    sw_mode = 1'b1;
    sw_pos  = 1'b1;
    sw_inc  = 1'b1;
    rst_n   = 1'b0;
    step(2);
    expect_at(cyc, "in_reset", RstVal, MAll);
    step(1);
    rst_n = 1'b1;
    r0    = cyc;
    expect_at(cyc, "after_reset", RstVal, MAll);
  endtask

  // Effect of a press lands on edge start+8 (DEBOUNCE_CYC+4); each press takes 16 cycles.
  task automatic press(input logic [2:0] b);
    if (b[0]) sw_mode = 1'b0;
    if (b[1]) sw_pos = 1'b0;
    if (b[2]) sw_inc = 1'b0;
    step(8);
    sw_mode = 1'b1;
    sw_pos  = 1'b1;
    sw_inc  = 1'b1;
    step(8);
  endtask

  task automatic press_n(input logic [2:0] b, input int n);
    for (int i = 0; i < n; i++) press(b);
  endtask

  task automatic wait_phase(input int p);
    for (int i = 0; i < 10 && ((cyc - r0) % 10) != p; i++) step(1);
  endtask

  function automatic int tick_after(input int c);
    return c + 10 - ((c - r0) % 10);
  endfunction

  // Leaves the DUT in ALARM mode with alarm 00:02 armed and time 00:01:50 + elapsed ticks.
  task automatic alarm_setup();
    int e1;
    do_reset();
    press(BMode);
    press_n(BInc, 50);
    press(BPos);
    press(BInc);
    expect_at(cyc, "set_0150", pk(0, 1, 50, 1, 1, 0, 0, 0), MTime | MMode);
    e1 = cyc + 8;
    expect_at(e1, "alarm_view0", pk(0, 0, 0, 2, 0, 0, 0, 0), MTime | MMode | MEn);
    press(BMode);
    press(BInc);
    press(BPos);
    press_n(BInc, 2);
    expect_at(cyc, "alarm_set", pk(0, 2, 0, 2, 1, 1, 0, 0), MTime | MMode | MEn | MAl);
  endtask

  initial begin : stim
    int s, e2, t1, t2;

    // Free-running count and blink phase.
    do_reset();
    n_vec++;
    if ((o_hour !== 5'd0) || (o_min !== 6'd0) || (o_sec !== 6'd0) || (o_mode !== 2'd0) ||
        (o_alarm !== 1'b0)) begin
      n_fail++;
      $display("FAIL direct_reset: %0d:%0d:%0d mode %0d alarm %b", o_hour, o_min, o_sec,
               o_mode, o_alarm);
    end
    for (int i = 0; i < 20; i++) expect_at(r0 + i, "blink", pk(0, 0, 0, 0, 0, 0, 0, (i % 10) < 5), MBl);
    expect_at(r0 + 9, "pre_tick", pk(0, 0, 0, 0, 0, 0, 0, 0), MTime);
    expect_at(r0 + 10, "first_tick", pk(0, 0, 1, 0, 0, 0, 0, 0), MTime);
    expect_at(r0 + 599, "t_000059", pk(0, 0, 59, 0, 0, 0, 0, 0), MTime | MMode);
    expect_at(r0 + 600, "t_000100", pk(0, 1, 0, 0, 0, 0, 0, 0), MTime | MMode);
    step(605);
    n_vec++;
    if ((o_hour !== 5'd0) || (o_min !== 6'd1) || (o_sec !== 6'd0) || (o_mode !== 2'd0)) begin
      n_fail++;
      $display("FAIL direct_000100: got %0d:%0d:%0d mode %0d", o_hour, o_min, o_sec, o_mode);
    end

    // Preload 23:59:58 in SETUP; one tick passes while in ALARM, cascade wrap in CLOCK.
    do_reset();
    expect_at(r0 + 7, "mode_latency", pk(0, 0, 0, 0, 0, 0, 0, 0), MMode);
    expect_at(r0 + 8, "to_setup", pk(0, 0, 0, 1, 0, 0, 0, 0), MTime | MMode);
    press(BMode);
    press_n(BInc, 58);
    expect_at(cyc, "sec58", pk(0, 0, 58, 1, 0, 0, 0, 0), MTime | MMode);
    press(BPos);
    press_n(BInc, 59);
    expect_at(cyc, "min59", pk(0, 59, 58, 1, 1, 0, 0, 0), MTime | MMode);
    press(BPos);
    press_n(BInc, 23);
    expect_at(cyc, "hour23", pk(23, 59, 58, 1, 2, 0, 0, 0), MTime | MMode);
    wait_phase(3);
    s = cyc;
    expect_at(s + 8, "alarm_display", pk(0, 0, 0, 2, 0, 0, 0, 0), MTime | MMode | MEn | MAl);
    press(BMode);
    expect_at(s + 24, "clock_235959", pk(23, 59, 59, 0, 0, 0, 0, 0), MTime | MMode);
    expect_at(s + 26, "hold_235959", pk(23, 59, 59, 0, 0, 0, 0, 0), MTime);
    expect_at(s + 27, "wrap_000000", pk(0, 0, 0, 0, 0, 0, 0, 0), MTime | MMode);
    press(BMode);

    // Minute wrap via 61 presses, frozen time, glitch rejection, event priority.
    do_reset();
    press(BMode);
    press(BPos);
    press_n(BInc, 61);
    expect_at(cyc, "min61", pk(0, 1, 0, 1, 1, 0, 0, 0), MTime | MMode);
    step(200);
    expect_at(cyc, "frozen", pk(0, 1, 0, 1, 1, 0, 0, 0), MTime | MMode);
    n_vec++;
    if ((o_mode !== 2'd1) || (o_position !== 2'd1) || (o_min !== 6'd1) ||
        (o_sec !== 6'd0)) begin
      n_fail++;
      $display("FAIL direct_frozen: mode %0d pos %0d time %0d:%0d:%0d", o_mode, o_position,
               o_hour, o_min, o_sec);
    end
    sw_inc = 1'b0;
    step(3);
    sw_inc = 1'b1;
    step(12);
    expect_at(cyc, "glitch", pk(0, 1, 0, 1, 1, 0, 0, 0), MTime | MMode);
    press(BPos | BInc);
    expect_at(cyc, "pos_over_inc", pk(0, 1, 0, 1, 2, 0, 0, 0), MTime | MMode);
    wait_phase(3);
    s = cyc;
    expect_at(s + 8, "mode_over_inc", pk(0, 0, 0, 2, 0, 0, 0, 0), MTime | MMode | MEn);
    press(BMode | BInc);
    expect_at(s + 24, "mode_inc_time", pk(0, 1, 1, 0, 0, 0, 0, 0), MTime | MMode);
    press(BMode);

    // Alarm fires at 00:02:00 and auto-silences at 00:02:03.
    alarm_setup();
    e2 = cyc + 8;
    t1 = tick_after(e2);
    t2 = t1 + 10;
    expect_at(e2, "clock_0158", pk(0, 1, 58, 0, 0, 1, 0, 0), MTime | MMode | MEn | MAl);
    expect_at(t1 - 1, "pre_59", pk(0, 1, 58, 0, 0, 1, 0, 0), MTime | MAl);
    expect_at(t1, "t_0159", pk(0, 1, 59, 0, 0, 1, 0, 0), MTime | MAl);
    expect_at(t2 - 1, "no_early_ring", pk(0, 1, 59, 0, 0, 1, 0, 0), MTime | MAl);
    expect_at(t2, "ring_0200", pk(0, 2, 0, 0, 0, 1, 1, 0), MTime | MEn | MAl);
    expect_at(t2 + 10, "ring_0201", pk(0, 2, 1, 0, 0, 1, 1, 0), MTime | MAl);
    expect_at(t2 + 29, "ring_0202", pk(0, 2, 2, 0, 0, 1, 1, 0), MTime | MAl);
    expect_at(t2 + 30, "quiet_0203", pk(0, 2, 3, 0, 0, 1, 0, 0), MTime | MEn | MAl);
    expect_at(t2 + 40, "quiet_0204", pk(0, 2, 4, 0, 0, 1, 0, 0), MTime | MAl);
    press(BMode);
    step(t2 + 42 - cyc);

    // A press while ringing only silences.
    alarm_setup();
    e2 = cyc + 8;
    t2 = tick_after(e2) + 10;
    press(BMode);
    step(t2 - cyc);
    expect_at(t2 + 7, "ring_hold", pk(0, 2, 0, 0, 0, 1, 1, 0), MMode | MAl);
    expect_at(t2 + 8, "silenced", pk(0, 2, 0, 0, 0, 1, 0, 0), MTime | MMode | MEn | MAl);
    press(BPos);
    expect_at(t2 + 40, "stay_quiet", pk(0, 2, 4, 0, 0, 1, 0, 0), MTime | MMode | MAl);
    step(t2 + 42 - cyc);

    // Asynchronous reset mid-SETUP with mode held; exactly one event after release.
    do_reset();
    press(BMode);
    press(BPos);
    press_n(BInc, 2);
    expect_at(cyc, "pre_rst", pk(0, 2, 0, 1, 1, 0, 0, 0), MTime | MMode);
    sw_mode = 1'b0;
    step(2);
    rst_n = 1'b0;
    expect_at(cyc, "rst_async", RstVal, MAll);
    step(3);
    expect_at(cyc, "rst_held", RstVal, MAll);
    rst_n = 1'b1;
    r0    = cyc;
    expect_at(r0 + 7, "held_pre", pk(0, 0, 0, 0, 0, 0, 0, 0), MMode);
    expect_at(r0 + 8, "held_event", pk(0, 0, 0, 1, 0, 0, 0, 0), MMode);
    expect_at(r0 + 40, "held_once", pk(0, 0, 0, 1, 0, 0, 0, 0), MMode);
    step(41);
    sw_mode = 1'b1;
    step(10);
    n_vec++;
    if ((o_mode !== 2'd1) || (o_position !== 2'd0)) begin
      n_fail++;
      $display("FAIL direct_release: mode %0d pos %0d", o_mode, o_position);
    end

    for (int i = 0; i < 100 && sb.size() > 0; i++) step(1);
    foreach (sb[i]) begin
      n_vec++;
      n_fail++;
      $display("FAIL %s: never checked (due %0d, now %0d)", sb[i].name, sb[i].due, cyc);
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation did not finish, cyc %0d", cyc);
    $fatal(1, "timeout");
  end

endmodule
